alu_op_decode: RTL

- Registered decode stage that turns RV32I OP (0110011) and OP-IMM (0010011) instruction words into the 6-bit op code consumed by the 32-bit ALU.
- Also produces register indices, the second-operand immediate, and an illegal flag.
- Sits between fetch and register-read/execute, with valid/ready handshakes on both sides.
- Holds a main output register plus a one-entry skid buffer: full throughput, and in_ready is driven from a register.

---
 rtl/alu_op_decode.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/alu_op_decode.sv
// alu_op_decode: registered decode stage for RV32I OP / OP-IMM instruction words.
// Turns each accepted word into the 6-bit ALU op code, the register indices,
// the second-operand immediate and the alu/illegal flags. It has a main output
// register and a one-entry skid buffer, so it runs at full throughput while
// in_ready still comes straight from a flop.
//
// Ports:
//   clk, reset            clock; asynchronous active-high reset
//   flush                 synchronous discard of all held entries
//   in_valid/in_ready     upstream handshake (in_ready registered, = !skid valid)
//   in_instr, in_pc       instruction word and its address
//   out_valid/out_ready   downstream handshake
//   out_op                {imm form, alt, alu, funct3}
//   out_rs1/rs2/rd        register indices (rs2 = 0 for OP-IMM)
//   out_imm               second-operand immediate (0 for OP)
//   out_alu, out_illegal  legal ALU instruction / malformed instruction
//   out_pc                in_pc of the presented entry
module alu_op_decode #(
  parameter int unsigned PC_W = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [5:0]      out_op,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [31:0]     out_imm,
  output logic            out_alu,
  output logic            out_illegal,
  output logic [PC_W-1:0] out_pc
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned OP_W  = 6;
  localparam int unsigned REG_W = 5;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] F7_ZERO    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [REG_W-1:0] rd;
    logic [XLEN-1:0]  imm;
    logic             alu;
    logic             illegal;
    logic [PC_W-1:0]  pc;
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t state_q;
  entry_t main_q;
  entry_t skid_q;
  logic   in_ready_q;
  logic   out_valid_q;
  entry_t dec_d;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       in_fire;
  logic       out_fire;

  assign opcode   = in_instr[6:0];
  assign funct3   = in_instr[14:12];
  assign funct7   = in_instr[31:25];
  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = out_valid_q & out_ready;

  // Combinational decode of the incoming word; captured only on in_fire.
  logic             imm_legal;
  logic             imm_alt;
  logic [XLEN-1:0]  imm_val;
  always_comb begin
    imm_legal = 1'b1;
    imm_alt   = 1'b0;
    imm_val   = {{20{in_instr[31]}}, in_instr[31:20]};
    if (funct3 == 3'b001) begin
      imm_legal = (funct7 == F7_ZERO);
      imm_val   = {27'b0, in_instr[24:20]};
    end else if (funct3 == 3'b101) begin
      imm_legal = (funct7 == F7_ZERO) || (funct7 == F7_ALT);
      imm_alt   = in_instr[30];
      imm_val   = {27'b0, in_instr[24:20]};
    end

    dec_d     = '0;
    dec_d.rs1 = in_instr[19:15];
    dec_d.rs2 = in_instr[24:20];
    dec_d.rd  = in_instr[11:7];
    dec_d.pc  = in_pc;
    if (in_instr[1:0] != 2'b11) begin
      dec_d.illegal = 1'b1;
    end else if (opcode == OPC_OP) begin
      if ((funct7 == F7_ZERO) ||
          ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)))) begin
        dec_d.alu = 1'b1;
        dec_d.op  = {1'b0, in_instr[30], 1'b1, funct3};
      end else begin
        dec_d.illegal = 1'b1;
      end
    end else if (opcode == OPC_OP_IMM) begin
      dec_d.rs2 = '0;
      if (imm_legal) begin
        dec_d.alu = 1'b1;
        dec_d.op  = {1'b1, imm_alt, 1'b1, funct3};
        dec_d.imm = imm_val;
      end else begin
        dec_d.illegal = 1'b1;
      end
    end
  end

  // Main/skid occupancy FSM with registered handshake outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else if (flush) begin
      state_q     <= EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            main_q      <= dec_d;
            state_q     <= ONE;
            out_valid_q <= 1'b1;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_q <= dec_d;
          end else if (in_fire) begin
            skid_q     <= dec_d;
            state_q    <= TWO;
            in_ready_q <= 1'b0;
          end else if (out_fire) begin
            state_q     <= EMPTY;
            out_valid_q <= 1'b0;
          end
        end
        TWO: begin
          // in_ready is low here, so only the drain side can move.
          if (out_fire) begin
            main_q     <= skid_q;
            state_q    <= ONE;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= EMPTY;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_op      = main_q.op;
  assign out_rs1     = main_q.rs1;
  assign out_rs2     = main_q.rs2;
  assign out_rd      = main_q.rd;
  assign out_imm     = main_q.imm;
  assign out_alu     = main_q.alu;
  assign out_illegal = main_q.illegal;
  assign out_pc      = main_q.pc;

endmodule
